bpred_btb: RTL and testbench

- Parametrised branch target buffer with N-bit saturating direction counters.
- Supersedes the single-bit prediction table in the IF stage of the pipelined RISC-V core.
- IF queries it combinationally with the fetch PC. ID writes back resolved branch/jump outcomes.
- Adds partial tags, configurable depth and counter width, and a sequential invalidate-all engine for context switches and self-modifying code.

---
 rtl/bpred_btb.sv | 139 +++++++++++++
 tb/tb_bpred_btb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpred_btb.sv
`default_nettype none
// ============================================================================
// bpred_btb : direct-mapped branch target buffer with partial tags, saturating
//             direction counters and a sequential invalidate-all engine.
// Revision  : 1.0
// ============================================================================
module bpred_btb #(
    parameter int PC_W    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            enable,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_uncond,
    input  logic [PC_W-1:0] upd_target,
    input  logic            inval_req,
    output logic            inval_busy
);

    localparam int               IDX_W      = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_WT   = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] C_CNT_WNT  = C_CNT_WT - CNT_W'(1);
    localparam logic [IDX_W-1:0] C_PTR_LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic             busy_q;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_en;
    logic [CNT_W-1:0] cnt_d;
    logic             w_unused_upd_pc;

    assign w_lk_idx = lookup_pc[2 +: IDX_W];
    assign w_lk_tag = lookup_pc[2 + IDX_W +: TAG_W];
    assign w_up_idx = upd_pc[2 +: IDX_W];
    assign w_up_tag = upd_pc[2 + IDX_W +: TAG_W];
    assign w_unused_upd_pc = ^upd_pc;

    // Lookups see pre-update contents; a pending clear makes everything miss.
    assign pred_hit     = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag) && !busy_q;
    assign pred_taken   = pred_hit && cnt_q[w_lk_idx][CNT_W-1];
    assign pred_next_pc = pred_taken ? tgt_q[w_lk_idx] : lookup_pc + PC_W'(4);
    assign inval_busy   = busy_q;

    assign w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);
    assign w_up_en  = enable && upd_valid && (state_q == ST_IDLE) && !inval_req;

    always_comb begin
        cnt_d = cnt_q[w_up_idx];
        if (w_up_hit) begin
            if (upd_uncond) begin
                cnt_d = C_CNT_MAX;
            end else if (upd_taken) begin
                if (cnt_q[w_up_idx] != C_CNT_MAX) cnt_d = cnt_q[w_up_idx] + CNT_W'(1);
            end else begin
                if (cnt_q[w_up_idx] != '0) cnt_d = cnt_q[w_up_idx] - CNT_W'(1);
            end
        end else begin
            cnt_d = upd_uncond ? C_CNT_MAX : C_CNT_WT;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (inval_req) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (ptr_q == C_PTR_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Clearing only drops valid bits; counters and targets are left as they are.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= C_CNT_WNT;
            end
        end else if (state_q == ST_CLEAR) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (w_up_en && (w_up_hit || upd_taken)) begin
            cnt_q[w_up_idx] <= cnt_d;
            if (upd_taken) tgt_q[w_up_idx] <= upd_target;
            if (!w_up_hit) begin
                valid_q[w_up_idx] <= 1'b1;
                tag_q[w_up_idx]   <= w_up_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpred_btb.sv
`default_nettype none
// Testbench for bpred_btb: directed scenarios plus random traffic against a
// behavioural model of the predictor table.
`timescale 1ns/1ps
module tb_bpred_btb;

    localparam int PC_W    = 64;
    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int WT      = 1 << (CNT_W - 1);
    localparam int WNT     = WT - 1;

    logic            clk = 1'b0;
    logic            arst_n;
    logic            enable;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_next_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_uncond;
    logic [PC_W-1:0] upd_target;
    logic            inval_req;
    logic            inval_busy;

    always #5 clk = ~clk;

    bpred_btb #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .lookup_pc    (lookup_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_uncond   (upd_uncond),
        .upd_target   (upd_target),
        .inval_req    (inval_req),
        .inval_busy   (inval_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference table
    bit              m_valid [ENTRIES];
    int              m_tag   [ENTRIES];
    logic [PC_W-1:0] m_tgt   [ENTRIES];
    int              m_cnt   [ENTRIES];
    int              m_clr_left;

    task automatic chk(input string tag, input logic [PC_W-1:0] got, input logic [PC_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int f_idx(input logic [PC_W-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int f_tag(input logic [PC_W-1:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_cnt[i]   = WNT;
        end
        m_clr_left = 0;
    endtask

    task automatic check_outputs(input string where);
        int              i;
        bit              hit;
        bit              tk;
        logic [PC_W-1:0] nx;
        i   = f_idx(lookup_pc);
        hit = (m_clr_left == 0) && m_valid[i] && (m_tag[i] == f_tag(lookup_pc));
        tk  = hit && (m_cnt[i] >= WT);
        nx  = tk ? m_tgt[i] : lookup_pc + 64'd4;
        chk({where, ".hit"},   {63'd0, pred_hit},   {63'd0, hit});
        chk({where, ".taken"}, {63'd0, pred_taken}, {63'd0, tk});
        chk({where, ".next"},  pred_next_pc,        nx);
        chk({where, ".busy"},  {63'd0, inval_busy}, {63'd0, m_clr_left > 0});
    endtask

    task automatic model_edge();
        int i;
        bit hit;
        if (m_clr_left > 0) begin
            m_valid[ENTRIES - m_clr_left] = 1'b0;
            m_clr_left--;
        end else if (inval_req) begin
            m_clr_left = ENTRIES;
        end else if (enable && upd_valid) begin
            i   = f_idx(upd_pc);
            hit = m_valid[i] && (m_tag[i] == f_tag(upd_pc));
            if (hit) begin
                if (upd_uncond)     m_cnt[i] = CMAX;
                else if (upd_taken) m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                else                m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                if (upd_taken) m_tgt[i] = upd_target;
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = f_tag(upd_pc);
                m_tgt[i]   = upd_target;
                m_cnt[i]   = upd_uncond ? CMAX : WT;
            end
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, step.
    task automatic cycle(input string where);
        @(negedge clk);
        check_outputs(where);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        upd_valid  = 1'b0;
        upd_taken  = 1'b0;
        upd_uncond = 1'b0;
        inval_req  = 1'b0;
    endtask

    task automatic do_upd(input logic [PC_W-1:0] pc, input bit tk, input bit unc,
                          input logic [PC_W-1:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_uncond = unc;
        upd_target = tgt;
        cycle("upd");
        set_idle();
    endtask

    task automatic look(input logic [PC_W-1:0] pc);
        lookup_pc = pc;
        cycle("look");
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        model_reset();
        #7;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;

    initial begin
        arst_n     = 1'b0;
        enable     = 1'b1;
        lookup_pc  = 64'h100;
        upd_pc     = '0;
        upd_target = '0;
        set_idle();
        model_reset();
        #12;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst.hit",   {63'd0, pred_hit},   64'd0);
        chk("rst.taken", {63'd0, pred_taken}, 64'd0);
        chk("rst.next",  pred_next_pc,        64'h104);
        chk("rst.busy",  {63'd0, inval_busy}, 64'd0);
        lookup_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        chk("wrap.next", pred_next_pc, 64'd0);
        look(64'hFFFF_FFFF_FFFF_FFFC);

        // Allocation, with a same-cycle lookup that must see old contents
        lookup_pc = 64'h100;
        do_upd(64'h100, 1'b1, 1'b0, 64'h80);
        look(64'h100);
        chk("alloc.next", pred_next_pc, 64'h80);

        // Counter walk
        for (int k = 0; k < 3; k++) do_upd(64'h100, 1'b0, 1'b0, 64'h0);
        chk("walk_nt.taken", {63'd0, pred_taken}, 64'd0);
        chk("walk_nt.next",  pred_next_pc,        64'h104);
        do_upd(64'h100, 1'b1, 1'b0, 64'h80);
        chk("walk_t1.taken", {63'd0, pred_taken}, 64'd0);
        for (int k = 0; k < 3; k++) do_upd(64'h100, 1'b1, 1'b0, 64'h80);
        do_upd(64'h100, 1'b0, 1'b0, 64'h0);
        chk("walk_sat.taken", {63'd0, pred_taken}, 64'd1);

        // Aliasing
        look(64'h140);
        do_upd(64'h140, 1'b1, 1'b0, 64'h200);
        lookup_pc = 64'h140;
        #1;
        chk("alias.next", pred_next_pc, 64'h200);
        look(64'h100);
        chk("alias.old_hit", {63'd0, pred_hit}, 64'd0);
        do_upd(64'h300, 1'b0, 1'b0, 64'h0);
        look(64'h300);
        chk("nt_miss.hit", {63'd0, pred_hit}, 64'd0);

        // Invalidate-all
        for (int k = 0; k < ENTRIES; k++)
            do_upd(64'h100 + 64'(k * 4), 1'b1, 1'b0, 64'h1000 + 64'(k * 16));
        look(64'h108);
        inval_req = 1'b1;
        cycle("inval_req");
        inval_req = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 40 && inval_busy; k++) begin
            busy_cnt++;
            upd_valid  = (k == 3);
            upd_taken  = 1'b1;
            upd_pc     = 64'h104;
            upd_target = 64'h7770;
            inval_req  = (k == 5);
            cycle("busy");
            set_idle();
        end
        chk("inval.busy_cycles", 64'(busy_cnt), 64'd16);
        for (int k = 0; k < ENTRIES; k++) begin
            look(64'h100 + 64'(k * 4));
            chk("inval.miss", {63'd0, pred_hit}, 64'd0);
        end

        // Reset during clear
        for (int k = 0; k < 4; k++) do_upd(64'h100 + 64'(k * 4), 1'b1, 1'b0, 64'h500);
        inval_req = 1'b1;
        cycle("inval_req2");
        inval_req = 1'b0;
        for (int k = 0; k < 5; k++) cycle("busy2");
        #2;
        arst_n = 1'b0;
        #1;
        chk("rst_mid.busy", {63'd0, inval_busy}, 64'd0);
        model_reset();
        #3;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        look(64'h104);
        chk("rst_mid.hit", {63'd0, pred_hit}, 64'd0);

        // enable low blocks updates
        enable = 1'b0;
        do_upd(64'h100, 1'b1, 1'b0, 64'h999);
        enable = 1'b1;
        look(64'h100);
        chk("en0.hit", {63'd0, pred_hit}, 64'd0);

        // Unconditional miss allocates at max: one not-taken keeps it taken
        do_upd(64'h180, 1'b1, 1'b1, 64'h400);
        do_upd(64'h180, 1'b0, 1'b0, 64'h0);
        look(64'h180);
        chk("uncond.taken", {63'd0, pred_taken}, 64'd1);
        chk("uncond.next",  pred_next_pc,        64'h400);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 19) == 0)
                lookup_pc = {$urandom, $urandom};
            else
                lookup_pc = 64'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
            upd_pc     = 64'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
            enable     = ($urandom_range(0, 9) != 0);
            upd_valid  = ($urandom_range(0, 9) < 6);
            upd_taken  = $urandom_range(0, 1) == 1;
            upd_uncond = ($urandom_range(0, 7) == 0);
            upd_target = {$urandom, $urandom};
            inval_req  = ($urandom_range(0, 59) == 0);
            cycle("rand");
        end
        set_idle();
        enable = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
